// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared types for the pipelined core. Provides the 32-bit word
//               type, the PC source select encoding and the state encoding of
//               the PC controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // PC source select driven towards the PC unit
  typedef enum logic [1:0] {
    PC_NPC = 2'b00,  // PC + 4
    PC_BR  = 2'b01,  // branch target
    PC_JMP = 2'b10,  // jump immediate
    PC_REG = 2'b11   // register (JR)
  } pcsrc_t;

  // PC controller phases
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    RESOLVE  = 2'b01,
    REDIRECT = 2'b10,
    HALTED   = 2'b11
  } pcctrl_state_t;

  // Resolve latency is bounded to 1..7, so the countdown fits in 3 bits
  localparam int RLAT_W = 3;
  typedef logic [RLAT_W-1:0] rlat_t;

endpackage
`default_nettype wire

// File: rtl/pc_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_if
// Description : Bundle between the PC controller and the PC register unit.
//   pcenable  PC write enable
//   pcsrc     next-PC source select
//   branch    taken-branch qualifier
//   BEQ       polarity of the branch in flight (1 = BEQ)
//   zero_f    sampled ALU zero flag
//   immed     jump immediate
//   immedEXT  sign-extended branch immediate
//   rdat1     register operand for JR
//   Modports: ctrl (driver side, used by pc_ctrl), pcu (PC unit side).
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_if;
  import cpu_types_pkg::*;

  logic        pcenable;
  pcsrc_t      pcsrc;
  logic        branch;
  logic        BEQ;
  logic        zero_f;
  logic [15:0] immed;
  word_t       immedEXT;
  word_t       rdat1;

  modport ctrl (
    output pcenable, pcsrc, branch, BEQ, zero_f, immed, immedEXT, rdat1
  );

  modport pcu (
    input pcenable, pcsrc, branch, BEQ, zero_f, immed, immedEXT, rdat1
  );

endinterface
`default_nettype wire

// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_ctrl
// Description : Controller-side driver of the PC interface. Sequences the PC
//               unit through RUN, RESOLVE, REDIRECT and HALTED from decode
//               control flow and the execute-stage zero flag.
// Ports       :
//   CLK, RST          clock, asynchronous active-high reset
//   ihit, stall       fetch return / hazard stall
//   id_*              decode-stage control flow and operands
//   ex_zero           ALU zero flag from execute
//   pc (pc_if.ctrl)   PC unit bundle (pcenable, pcsrc, branch, BEQ, zero_f,
//                     immed, immedEXT, rdat1)
//   flush_ifid        one-cycle IF/ID flush pulse
//   halt              sticky halted indication
//   br_cnt, taken_cnt resolved / taken branch counters (PC_CTRL_PERF_EN only)
// Options     : define PC_CTRL_PERF_EN to add the branch performance counters
//               and the CNT_W parameter.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ctrl
  import cpu_types_pkg::*;
#(
  parameter int RESOLVE_LAT = 1
`ifdef PC_CTRL_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        stall,
  input  logic        id_valid,
  input  logic        id_branch,
  input  logic        id_beq,
  input  logic        id_jump,
  input  logic        id_jr,
  input  logic        id_halt,
  input  logic [15:0] id_immed,
  input  word_t       id_immedEXT,
  input  word_t       id_rdat1,
  input  logic        ex_zero,
  pc_if.ctrl          pc,
  output logic        flush_ifid,
  output logic        halt
`ifdef PC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
`endif
);

  pcctrl_state_t state, state_nxt;

  pcsrc_t      pcsrc_reg,    pcsrc_nxt;
  logic        branch_reg,   branch_nxt;
  logic        beq_reg,      beq_nxt;
  logic        zf_reg,       zf_nxt;
  logic [15:0] immed_reg,    immed_nxt;
  word_t       immext_reg,   immext_nxt;
  word_t       rdat1_reg,    rdat1_nxt;
  logic        flush_reg,    flush_nxt;
  logic        halt_reg,     halt_nxt;
  rlat_t       cnt_reg,      cnt_nxt;
  logic        pcenable_c;
  logic        taken;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= RUN;
      pcsrc_reg  <= PC_NPC;
      branch_reg <= 1'b0;
      beq_reg    <= 1'b0;
      zf_reg     <= 1'b0;
      immed_reg  <= '0;
      immext_reg <= '0;
      rdat1_reg  <= '0;
      flush_reg  <= 1'b0;
      halt_reg   <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state      <= state_nxt;
      pcsrc_reg  <= pcsrc_nxt;
      branch_reg <= branch_nxt;
      beq_reg    <= beq_nxt;
      zf_reg     <= zf_nxt;
      immed_reg  <= immed_nxt;
      immext_reg <= immext_nxt;
      rdat1_reg  <= rdat1_nxt;
      flush_reg  <= flush_nxt;
      halt_reg   <= halt_nxt;
      cnt_reg    <= cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and next register values
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    pcsrc_nxt  = pcsrc_reg;
    branch_nxt = branch_reg;
    beq_nxt    = beq_reg;
    zf_nxt     = zf_reg;
    immed_nxt  = immed_reg;
    immext_nxt = immext_reg;
    rdat1_nxt  = rdat1_reg;
    flush_nxt  = 1'b0;          // flush is a single-cycle pulse
    halt_nxt   = halt_reg;
    cnt_nxt    = cnt_reg;
    pcenable_c = 1'b0;
    taken      = 1'b0;

    case (state)
      RUN: begin
        pcenable_c = ihit & ~stall;
        if (id_valid && !stall) begin
          // Priority: halt > jump > jr > branch
          if (id_halt) begin
            halt_nxt  = 1'b1;
            state_nxt = HALTED;
          end else if (id_jump) begin
            immed_nxt = id_immed;
            pcsrc_nxt = PC_JMP;
            flush_nxt = 1'b1;
            state_nxt = REDIRECT;
          end else if (id_jr) begin
            rdat1_nxt = id_rdat1;
            pcsrc_nxt = PC_REG;
            flush_nxt = 1'b1;
            state_nxt = REDIRECT;
          end else if (id_branch) begin
            immext_nxt = id_immedEXT;
            beq_nxt    = id_beq;
            cnt_nxt    = rlat_t'(RESOLVE_LAT - 1);
            state_nxt  = RESOLVE;
          end
        end
      end

      RESOLVE: begin
        if (!stall) begin
          if (cnt_reg == '0) begin
            zf_nxt = ex_zero;
            taken  = beq_reg ? ex_zero : ~ex_zero;
            if (taken) begin
              pcsrc_nxt  = PC_BR;
              branch_nxt = 1'b1;
              flush_nxt  = 1'b1;
              state_nxt  = REDIRECT;
            end else begin
              pcsrc_nxt  = PC_NPC;
              branch_nxt = 1'b0;
              state_nxt  = RUN;
            end
          end else begin
            cnt_nxt = cnt_reg - rlat_t'(1);
          end
        end
      end

      REDIRECT: begin
        // Redirect target is held until the fetch actually returns
        pcenable_c = ihit;
        if (ihit) begin
          pcsrc_nxt  = PC_NPC;
          branch_nxt = 1'b0;
          state_nxt  = RUN;
        end
      end

      HALTED: begin
        halt_nxt = 1'b1;
      end

      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pc.pcenable = pcenable_c;
  assign pc.pcsrc    = pcsrc_reg;
  assign pc.branch   = branch_reg;
  assign pc.BEQ      = beq_reg;
  assign pc.zero_f   = zf_reg;
  assign pc.immed    = immed_reg;
  assign pc.immedEXT = immext_reg;
  assign pc.rdat1    = rdat1_reg;
  assign flush_ifid  = flush_reg;
  assign halt        = halt_reg;

`ifdef PC_CTRL_PERF_EN
  // Branch statistics: every RESOLVE exit counts, taken exits go to REDIRECT.
  // Counters cannot move in HALTED since RESOLVE is never reached from there.
  logic [CNT_W-1:0] br_cnt_reg;
  logic [CNT_W-1:0] taken_cnt_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      br_cnt_reg    <= '0;
      taken_cnt_reg <= '0;
    end else if (state == RESOLVE && state_nxt != RESOLVE) begin
      br_cnt_reg <= br_cnt_reg + CNT_W'(1);
      if (state_nxt == REDIRECT) begin
        taken_cnt_reg <= taken_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign br_cnt    = br_cnt_reg;
  assign taken_cnt = taken_cnt_reg;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_ctrl
// Description : Self-checking bench for pc_ctrl. Two instances (resolve
//               latency 1 and 3) share the same stimulus; each is compared
//               every cycle against a behavioural model of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit, stall, id_valid, id_branch, id_beq, id_jump, id_jr, id_halt;
  logic [15:0] id_immed;
  logic [31:0] id_immedEXT, id_rdat1;
  logic        ex_zero;

  always #5 CLK = ~CLK;

  pc_if pif0 ();
  pc_if pif1 ();
  logic flush0, halt0, flush1, halt1;
`ifdef PC_CTRL_PERF_EN
  logic [31:0] brc0, tkc0, brc1, tkc1;
`endif

  pc_ctrl #(.RESOLVE_LAT(1)) dut0 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .stall(stall), .id_valid(id_valid),
    .id_branch(id_branch), .id_beq(id_beq), .id_jump(id_jump), .id_jr(id_jr),
    .id_halt(id_halt), .id_immed(id_immed), .id_immedEXT(id_immedEXT),
    .id_rdat1(id_rdat1), .ex_zero(ex_zero), .pc(pif0),
    .flush_ifid(flush0), .halt(halt0)
`ifdef PC_CTRL_PERF_EN
    , .br_cnt(brc0), .taken_cnt(tkc0)
`endif
  );

  pc_ctrl #(.RESOLVE_LAT(3)) dut1 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .stall(stall), .id_valid(id_valid),
    .id_branch(id_branch), .id_beq(id_beq), .id_jump(id_jump), .id_jr(id_jr),
    .id_halt(id_halt), .id_immed(id_immed), .id_immedEXT(id_immedEXT),
    .id_rdat1(id_rdat1), .ex_zero(ex_zero), .pc(pif1),
    .flush_ifid(flush1), .halt(halt1)
`ifdef PC_CTRL_PERF_EN
    , .br_cnt(brc1), .taken_cnt(tkc1)
`endif
  );

  typedef struct packed {
    logic        pcen;
    logic [1:0]  pcsrc;
    logic        branch;
    logic        beq;
    logic        zf;
    logic [15:0] immed;
    logic [31:0] immext;
    logic [31:0] rdat1;
    logic        flush;
    logic        halt;
  } obs_t;

  obs_t obs [2];
  assign obs[0] = '{pif0.pcenable, pif0.pcsrc, pif0.branch, pif0.BEQ, pif0.zero_f,
                    pif0.immed, pif0.immedEXT, pif0.rdat1, flush0, halt0};
  assign obs[1] = '{pif1.pcenable, pif1.pcsrc, pif1.branch, pif1.BEQ, pif1.zero_f,
                    pif1.immed, pif1.immedEXT, pif1.rdat1, flush1, halt1};

  // ---------------- behavioural model ----------------
  int          lat [2] = '{1, 3};
  bit          m_halted [2];
  bit          m_redir  [2];
  int          m_left   [2];   // cycles left before resolution, -1 when idle
  logic [1:0]  m_pcsrc  [2];
  bit          m_branch [2];
  bit          m_beq    [2];
  bit          m_zf     [2];
  bit          m_flush  [2];
  logic [15:0] m_immed  [2];
  logic [31:0] m_immext [2];
  logic [31:0] m_rdat1  [2];
  int unsigned m_br     [2];
  int unsigned m_tk     [2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_halted[k] = 0; m_redir[k] = 0; m_left[k] = -1;
      m_pcsrc[k] = 2'b00; m_branch[k] = 0; m_beq[k] = 0; m_zf[k] = 0;
      m_flush[k] = 0; m_immed[k] = '0; m_immext[k] = '0; m_rdat1[k] = '0;
      m_br[k] = 0; m_tk[k] = 0;
    end
  endtask

  task automatic model_step();
    bit tk;
    for (int k = 0; k < 2; k++) begin
      m_flush[k] = 0;
      if (m_halted[k]) begin
        // absorbing
      end else if (m_left[k] >= 0) begin
        if (!stall) begin
          if (m_left[k] == 0) begin
            tk = m_beq[k] ? ex_zero : !ex_zero;
            m_zf[k] = ex_zero;
            m_left[k] = -1;
            m_br[k]++;
            if (tk) begin
              m_tk[k]++;
              m_pcsrc[k] = 2'b01; m_branch[k] = 1; m_flush[k] = 1; m_redir[k] = 1;
            end else begin
              m_pcsrc[k] = 2'b00; m_branch[k] = 0;
            end
          end else begin
            m_left[k]--;
          end
        end
      end else if (m_redir[k]) begin
        if (ihit) begin
          m_redir[k] = 0; m_pcsrc[k] = 2'b00; m_branch[k] = 0;
        end
      end else if (id_valid && !stall) begin
        if (id_halt) m_halted[k] = 1;
        else if (id_jump) begin
          m_immed[k] = id_immed; m_pcsrc[k] = 2'b10; m_flush[k] = 1; m_redir[k] = 1;
        end else if (id_jr) begin
          m_rdat1[k] = id_rdat1; m_pcsrc[k] = 2'b11; m_flush[k] = 1; m_redir[k] = 1;
        end else if (id_branch) begin
          m_immext[k] = id_immedEXT; m_beq[k] = id_beq; m_left[k] = lat[k] - 1;
        end
      end
    end
  endtask

  task automatic check_pcen();
    bit exp;
    for (int k = 0; k < 2; k++) begin
      if (m_halted[k] || m_left[k] >= 0) exp = 0;
      else if (m_redir[k])               exp = ihit;
      else                               exp = ihit & ~stall;
      check($sformatf("pcenable%0d", k), obs[k].pcen, exp);
    end
  endtask

  task automatic check_regs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("pcsrc%0d", k),    obs[k].pcsrc,  m_pcsrc[k]);
      check($sformatf("branch%0d", k),   obs[k].branch, m_branch[k]);
      check($sformatf("BEQ%0d", k),      obs[k].beq,    m_beq[k]);
      check($sformatf("zero_f%0d", k),   obs[k].zf,     m_zf[k]);
      check($sformatf("immed%0d", k),    obs[k].immed,  m_immed[k]);
      check($sformatf("immedEXT%0d", k), obs[k].immext, m_immext[k]);
      check($sformatf("rdat1%0d", k),    obs[k].rdat1,  m_rdat1[k]);
      check($sformatf("flush%0d", k),    obs[k].flush,  m_flush[k]);
      check($sformatf("halt%0d", k),     obs[k].halt,   m_halted[k]);
    end
`ifdef PC_CTRL_PERF_EN
    check("br_cnt0", brc0, m_br[0]);  check("taken_cnt0", tkc0, m_tk[0]);
    check("br_cnt1", brc1, m_br[1]);  check("taken_cnt1", tkc1, m_tk[1]);
`endif
  endtask

  // ---------------- stimulus ----------------
  task automatic drive_idle(input bit hit);
    ihit = hit; stall = 0; id_valid = 0; id_branch = 0; id_beq = 0;
    id_jump = 0; id_jr = 0; id_halt = 0; ex_zero = 0;
    id_immed = '0; id_immedEXT = '0; id_rdat1 = '0;
  endtask

  task automatic drive_rand();
    ihit        = ($urandom % 4) != 0;
    stall       = ($urandom % 4) == 0;
    id_valid    = $urandom % 2;
    id_halt     = ($urandom % 40) == 0;
    id_jump     = ($urandom % 5) == 0;
    id_jr       = ($urandom % 5) == 0;
    id_branch   = ($urandom % 3) == 0;
    id_beq      = $urandom % 2;
    ex_zero     = $urandom % 2;
    id_immed    = 16'($urandom);
    id_immedEXT = $urandom;
    id_rdat1    = $urandom;
  endtask

  // Called at a negedge with inputs already driven
  task automatic tick();
    #1 check_pcen();
    @(posedge CLK);
    if (!RST) model_step();
    @(negedge CLK);
    check_regs();
  endtask

  // Asynchronous reset pulse inside the clock-low phase
  task automatic do_reset();
    RST = 1'b1;
    drive_idle(1'b0);
    #1;
    model_reset();
    check_regs();
    check_pcen();
    #1 RST = 1'b0;
  endtask

  initial begin
    drive_idle(1'b0);
    model_reset();
    #1 check_regs();
    @(negedge CLK);
    RST = 1'b0;

    // Plain fetch
    drive_idle(1'b1);
    repeat (4) tick();

    // BEQ taken with ex_zero = 1
    id_valid = 1; id_branch = 1; id_beq = 1; id_immedEXT = 32'h0000_0004;
    tick();
    drive_idle(1'b1); ex_zero = 1;
    repeat (6) tick();

    // BNE with ex_zero = 1: not taken
    id_valid = 1; id_branch = 1; id_beq = 0; id_immedEXT = 32'h0000_0010;
    tick();
    drive_idle(1'b1); ex_zero = 1;
    repeat (5) tick();

    // JR with ihit withheld for 3 cycles
    id_valid = 1; id_jr = 1; id_rdat1 = 32'h0000_0100;
    tick();
    drive_idle(1'b0);
    repeat (3) tick();
    ihit = 1;
    repeat (2) tick();

    // Branch with stall held two cycles mid-resolve
    id_valid = 1; id_branch = 1; id_beq = 1; id_immedEXT = 32'hFFFF_FFF8;
    tick();
    drive_idle(1'b1); ex_zero = 1;
    tick();
    stall = 1;
    repeat (2) tick();
    stall = 0;
    repeat (5) tick();

    // Halt together with a branch, then reset mid-HALTED
    id_valid = 1; id_halt = 1; id_branch = 1; id_immedEXT = 32'h1234_5678;
    tick();
    drive_idle(1'b1);
    repeat (3) tick();
    do_reset();
    drive_idle(1'b1);
    repeat (2) tick();

    // Randomized episodes, with occasional asynchronous resets mid-flight
    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        if (($urandom % 50) == 0) do_reset();
        drive_rand();
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Controller-side driver of the PC interface in the pipelined core. Takes decode-stage control-flow information and execute-stage ALU zero, and sequences the PC unit through four phases: normal fetch, branch resolution, redirect and halt. Drives pcenable, pcsrc, branch, BEQ, zero_f, immed, immedEXT and rdat1, and issues pipeline flushes. Sits between the decode/hazard logic and the PC register.

Parameters:
RESOLVE_LAT, 1, cycles between branch decode and a valid ex_zero (1..7)
CNT_W, 32, width of the optional performance counters

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
ihit  in  1  instruction memory returned fetch this cycle
stall  in  1  hazard unit stall; freezes FSM progress
id_valid  in  1  decode stage holds a valid instruction
id_branch  in  1  decoded BEQ/BNE
id_beq  in  1  1 = BEQ, 0 = BNE (valid with id_branch)
id_jump  in  1  decoded J/JAL
id_jr  in  1  decoded JR
id_halt  in  1  decoded HALT
id_immed  in  16  raw immediate field
id_immedEXT  in  32  sign-extended immediate
id_rdat1  in  32  register-file rs value
ex_zero  in  1  ALU zero flag from execute
pcenable  out  1  PC register write enable
pcsrc  out  2  00 PC+4, 01 branch target, 10 jump (immed), 11 register (rdat1)
branch  out  1  taken-branch qualifier to PC unit
BEQ  out  1  registered id_beq of the branch in flight
zero_f  out  1  sampled ex_zero
immed  out  16  captured immediate
immedEXT  out  32  captured extended immediate
rdat1  out  32  captured rs value
flush_ifid  out  1  one-cycle IF/ID flush pulse
halt  out  1  sticky halted indication

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high.
- Reset values: state RUN; every output 0 except pcsrc 00; counter 0.
- Output timing: all outputs are registered except pcenable, which is combinational from state, ihit and stall.
- States: RUN, RESOLVE, REDIRECT, HALTED.
- RUN:
  - pcenable = ihit & ~stall.
  - When id_valid & ~stall, priority is id_halt > id_jump > id_jr > id_branch.
  - id_halt -> HALTED; halt set next cycle.
  - id_jump -> capture id_immed; pcsrc = 10; -> REDIRECT.
  - id_jr -> capture id_rdat1; pcsrc = 11; -> REDIRECT.
  - id_branch -> capture id_immedEXT and id_beq; counter = RESOLVE_LAT - 1; -> RESOLVE.
  - With none of these, pcsrc stays 00.
- RESOLVE:
  - pcenable = 0.
  - The counter decrements each non-stalled cycle and holds while stall = 1.
  - At counter == 0 with stall = 0: zero_f <= ex_zero; taken = BEQ ? ex_zero : ~ex_zero.
  - Taken -> pcsrc = 01, branch = 1, flush_ifid pulses 1 for one cycle, -> REDIRECT.
  - Not taken -> pcsrc = 00, branch = 0, -> RUN.
- REDIRECT:
  - pcenable = ihit; pcsrc, branch and captured operands are held until ihit.
  - On the ihit cycle: next state RUN, and pcsrc <= 00, branch <= 0.
  - flush_ifid asserts for exactly the first REDIRECT cycle entered from RUN on jump/JR.
  - No new decode is accepted while in REDIRECT.
- HALTED: pcenable = 0 and halt = 1. HALTED is absorbing; only RST leaves it.
- Boundaries:
  - id_halt together with id_branch -> halt wins; the branch is ignored.
  - stall and ihit together in RUN -> pcenable 0.
  - RESOLVE_LAT = 1 -> resolve in the first RESOLVE cycle.
  - RST asserted in any state, including mid-RESOLVE -> immediate return to the reset values.
- Width: immed is passed unmodified. immedEXT and rdat1 are captured whole; no arithmetic is done here.

Optional Feature:
PC_CTRL_PERF_EN:
- Defined: adds outputs br_cnt and taken_cnt, each CNT_W bits, reset 0.
  - br_cnt increments on every RESOLVE exit.
  - taken_cnt increments on taken exits.
  - Both wrap modulo 2^CNT_W and freeze in HALTED.
- Undefined: the ports and the counters do not exist.

Decomposition:
- cpu_types_pkg gains pcsrc_t (PC_NPC = 2'b00, PC_BR = 2'b01, PC_JMP = 2'b10, PC_REG = 2'b11) and pcctrl_state_t (RUN, RESOLVE, REDIRECT, HALTED). word_t is reused for 32-bit fields.
- pc_ctrl also gets a modport on pc_if mirroring the tb direction.
- No sub-module; the optional counters stay inline under the macro.

Test Plan:
- Reset then ihit = 1 with no control flow -> pcenable = 1 each cycle, pcsrc = 00, halt = 0.
- BEQ (id_beq = 1, id_immedEXT = 32'h0000_0004) with ex_zero = 1 after 1 cycle -> pcenable 0 for 1 cycle; then pcsrc = 01, branch = 1, zero_f = 1, flush_ifid pulses once; back to pcsrc 00 after the ihit.
- BNE with ex_zero = 1 -> not taken; pcsrc stays 00, branch 0, no flush.
- JR with id_rdat1 = 32'h0000_0100 and ihit withheld 3 cycles -> pcsrc = 11 and rdat1 = 0x100 held for all 3 cycles; pcenable rises with ihit.
- RESOLVE_LAT = 3 with stall high 2 cycles mid-resolve -> resolution occurs exactly 5 cycles after decode.
- id_halt with id_branch, then RST pulsed mid-HALTED -> halt = 1 sticky and branch ignored; RST clears all outputs asynchronously.
